// File: rtl/kitchen_pkg.sv
// Shared types and widths for the kitchen-side restock responder.
package kitchen_pkg;

  localparam int unsigned QTY_W  = 6;
  localparam int unsigned RAW_W  = 8;
  localparam int unsigned NEED_W = 7;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SRV_W  = 16;

  localparam logic PROD_NUGGET = 1'b1;
  localparam logic PROD_RICE   = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_RAW,
    COOK,
    DONE
  } state_e;

  // Raw units consumed by one order: rice costs two units per portion.
  function automatic logic [NEED_W-1:0] raw_need(input logic prod, input logic [QTY_W-1:0] qty);
    return (prod == PROD_RICE) ? NEED_W'({qty, 1'b0}) : NEED_W'(qty);
  endfunction

endpackage

// File: rtl/kitchen_cook_timer.sv
// Loadable down-counter timing the COOK phase; last flags the final cook cycle.
module kitchen_cook_timer
  import kitchen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             en,
  output logic             last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/kitchen_supplier.sv
// Kitchen responder: checks and consumes raw stock, cooks for a quantity-proportional
// time and answers each restock request with a one-cycle ready_kitch.
module kitchen_supplier
  import kitchen_pkg::*;
#(
  parameter int unsigned CYC_NUGGET = 2,
  parameter int unsigned CYC_RICE   = 3,
  parameter int unsigned RAW_CAP    = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_kitch,
  input  logic             product_out,
  input  logic [QTY_W-1:0] number_out,
  input  logic             raw_fill,
  output logic             ready_kitch,
  output logic             raw_req,
  output logic             busy,
  output logic [RAW_W-1:0] raw_level,
  output logic [SRV_W-1:0] served_nugget,
  output logic [SRV_W-1:0] served_rice
);

  state_e            state;
  logic              prod_q;
  logic [QTY_W-1:0]  qty_q;
  logic [NEED_W-1:0] need;
  logic [CNT_W-1:0]  cyc_unit;
  logic [CNT_W-1:0]  cook_len;
  logic              enough;
  logic              cook_load;
  logic              cook_last;

  assign need      = raw_need(prod_q, qty_q);
  assign enough    = (raw_level >= RAW_W'(need));
  assign cyc_unit  = (prod_q == PROD_NUGGET) ? CNT_W'(CYC_NUGGET) : CNT_W'(CYC_RICE);
  assign cook_len  = CNT_W'(qty_q) * cyc_unit;
  assign cook_load = (state == CHECK) && valid_kitch && enough;

  kitchen_cook_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (cook_load),
    .value (cook_len),
    .en    (state == COOK),
    .last  (cook_last)
  );

  // Status outputs decode straight from the state register.
  assign ready_kitch = (state == DONE);
  assign raw_req     = (state == WAIT_RAW);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      prod_q        <= 1'b0;
      qty_q         <= '0;
      raw_level     <= RAW_W'(RAW_CAP);
      served_nugget <= '0;
      served_rice   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (raw_fill) raw_level <= RAW_W'(RAW_CAP);
          if (valid_kitch) begin
            prod_q <= product_out;
            qty_q  <= number_out;
            state  <= (number_out == '0) ? DONE : CHECK;
          end
        end
        CHECK: begin
          if (!valid_kitch) begin
            state <= IDLE;
          end else if (enough) begin
            raw_level <= raw_level - RAW_W'(need);
            state     <= COOK;
          end else begin
            state <= WAIT_RAW;
          end
        end
        WAIT_RAW: begin
          if (raw_fill) raw_level <= RAW_W'(RAW_CAP);
          if (!valid_kitch) state <= IDLE;
          else if (raw_fill) state <= CHECK;
        end
        COOK: begin
          if (!valid_kitch) state <= IDLE;
          else if (cook_last) state <= DONE;
        end
        DONE: begin
          if (prod_q == PROD_NUGGET) served_nugget <= served_nugget + SRV_W'(qty_q);
          else served_rice <= served_rice + SRV_W'(qty_q);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kitchen_supplier.sv
// Scoreboard bench for kitchen_supplier: directed scenarios plus randomized orders.
module tb_kitchen_supplier;

  localparam int CYC_NUGGET = 2;
  localparam int CYC_RICE   = 3;
  localparam int RAW_CAP    = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_kitch = 1'b0;
  logic        product_out = 1'b0;
  logic [5:0]  number_out = '0;
  logic        raw_fill = 1'b0;
  logic        ready_kitch;
  logic        raw_req;
  logic        busy;
  logic [7:0]  raw_level;
  logic [15:0] served_nugget;
  logic [15:0] served_rice;

  kitchen_supplier #(
    .CYC_NUGGET (CYC_NUGGET),
    .CYC_RICE   (CYC_RICE),
    .RAW_CAP    (RAW_CAP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_kitch   (valid_kitch),
    .product_out   (product_out),
    .number_out    (number_out),
    .raw_fill      (raw_fill),
    .ready_kitch   (ready_kitch),
    .raw_req       (raw_req),
    .busy          (busy),
    .raw_level     (raw_level),
    .served_nugget (served_nugget),
    .served_rice   (served_rice)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cycle;
    int          raw;
    logic [15:0] sn;
    logic [15:0] sr;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_raw = RAW_CAP;
  logic [15:0] m_sn = '0;
  logic [15:0] m_sr = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int t_ready, input bit prod, input int qty);
    exp_t e;
    if (prod) m_sn = m_sn + 16'(qty);
    else m_sr = m_sr + 16'(qty);
    e.cycle = t_ready;
    e.raw   = m_raw;
    e.sn    = m_sn;
    e.sr    = m_sr;
    sb.push_back(e);
  endtask

  // One order. abort_at: 0 none, -1 random point in COOK, >0 cycle offset at which valid drops.
  task automatic run_req(input bit prod, input int qty, input int abort_at,
                         input int fill_wait, input bit fill_cook, input bit fill_acc);
    int t0, need, cook, t_ready, ab, k;
    t0 = cyc;
    valid_kitch = 1'b1;
    product_out = prod;
    number_out  = 6'(qty);
    if (fill_acc) begin
      raw_fill = 1'b1;
      m_raw    = RAW_CAP;
    end
    need = qty * (prod ? 1 : 2);
    cook = qty * (prod ? CYC_NUGGET : CYC_RICE);
    t_ready = t0 + 1;
    if (qty == 0) push_exp(t_ready, prod, qty);
    @(negedge clk);
    raw_fill = 1'b0;
    if (qty != 0 && m_raw >= need) begin
      m_raw = m_raw - need;
      ab = abort_at;
      if (ab < 0) ab = int'($urandom_range(2, 1 + cook));
      @(negedge clk);
      chk("raw_after_check", int'(raw_level), m_raw);
      chk("busy_in_cook", int'(busy), 1);
      if (ab > 0) begin
        while (cyc < t0 + ab) @(negedge clk);
        valid_kitch = 1'b0;
        @(negedge clk);
        chk("busy_after_abort", int'(busy), 0);
        chk("raw_after_abort", int'(raw_level), m_raw);
        return;
      end
      t_ready = t0 + 2 + cook;
      push_exp(t_ready, prod, qty);
      if (fill_cook && cook >= 2) begin
        @(negedge clk);
        raw_fill = 1'b1;
        @(negedge clk);
        raw_fill = 1'b0;
      end
    end else if (qty != 0) begin
      @(negedge clk);
      chk("raw_req_waiting", int'(raw_req), 1);
      chk("raw_level_waiting", int'(raw_level), m_raw);
      repeat (fill_wait) @(negedge clk);
      raw_fill = 1'b1;
      k = cyc;
      m_raw   = RAW_CAP - need;
      t_ready = k + 2 + cook;
      push_exp(t_ready, prod, qty);
      @(negedge clk);
      raw_fill = 1'b0;
      chk("raw_req_after_fill", int'(raw_req), 0);
    end
    while (cyc < t_ready) @(negedge clk);
    valid_kitch = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every ready pulse pops one expectation; served totals are checked a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready_kitch === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ready at cycle %0d: got ready, expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("ready_cycle", cyc, e.cycle);
          chk("raw_at_ready", int'(raw_level), e.raw);
          @(negedge clk);
          chk("ready_width", int'(ready_kitch), 0);
          chk("served_nugget", int'(served_nugget), int'(e.sn));
          chk("served_rice", int'(served_rice), int'(e.sr));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, qty, r;
    repeat (2) @(negedge clk);
    chk("rst_raw_level", int'(raw_level), RAW_CAP);
    chk("rst_ready", int'(ready_kitch), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_raw_req", int'(raw_req), 0);
    chk("rst_served_n", int'(served_nugget), 0);
    chk("rst_served_r", int'(served_rice), 0);
    rst = 1'b0;
    @(negedge clk);

    run_req(1'b1, 5, 0, 0, 1'b0, 1'b0);
    run_req(1'b0, 0, 0, 0, 1'b0, 1'b1);
    run_req(1'b0, 63, 0, 0, 1'b0, 1'b0);
    run_req(1'b0, 63, 0, 3, 1'b0, 1'b0);
    run_req(1'b1, 0, 0, 0, 1'b0, 1'b0);
    run_req(1'b1, 10, 6, 0, 1'b0, 1'b1);
    run_req(1'b1, 8, 0, 0, 1'b1, 1'b0);
    run_req(1'b0, 40, 0, 1, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 9) == 0) begin
          raw_fill = 1'b1;
          m_raw    = RAW_CAP;
        end
        @(negedge clk);
        raw_fill = 1'b0;
      end
      r   = int'($urandom_range(0, 9));
      qty = (r == 0) ? 0 : (r == 1) ? 63 : int'($urandom_range(1, 62));
      run_req(1'($urandom_range(0, 1)), qty,
              ($urandom_range(0, 7) == 0) ? -1 : 0,
              int'($urandom_range(0, 4)),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset in the middle of COOK drops the order.
    t0 = cyc;
    valid_kitch = 1'b1;
    product_out = 1'b1;
    number_out  = 6'd20;
    while (cyc < t0 + 5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ready", int'(ready_kitch), 0);
    chk("async_rst_raw_req", int'(raw_req), 0);
    chk("async_rst_raw_level", int'(raw_level), RAW_CAP);
    chk("async_rst_served_n", int'(served_nugget), 0);
    chk("async_rst_served_r", int'(served_rice), 0);
    @(negedge clk);
    valid_kitch = 1'b0;
    rst = 1'b0;
    m_raw = RAW_CAP;
    m_sn  = '0;
    m_sr  = '0;
    @(negedge clk);

    run_req(1'b0, 7, 0, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
